lin_render: RTL
===============

// Module: lin_render
// PURPOSE
//  Consumer end of the per-line dark decision: takes the 1-bit line verdict (rx) produced by the
//  line-statistics buffer and applies it to the live pixel stream. Sits in the video path between
//  the input timing/pixel source and the output encoder. Hysteresis keeps the mode from flickering.
//  Mode changes occur only at line boundaries, so a single line is never split.
// PARAMETERS
//  BPC   8  bits per colour channel; pixel word is 3*BPC (R,G,B packed MSB..LSB)
//  HYST  4  consecutive agreeing line verdicts required to flip mode (>=1)
//  LAT   2  pixel-path pipeline depth in cycles (fixed; 2 is the only supported value)
// PORTS
//  clk_i     in   1       pixel clock
//  rst_ni    in   1       async active-low reset
//  freeze_i  in   1       1 = hold hysteresis counter and mode (verdicts ignored)
//  rx_i      in   1       line verdict from statistics buffer, 1 = line is bright -> go dark
//  hs_i      in   1       hsync, active-high
//  vs_i      in   1       vsync, active-high
//  de_i      in   1       data enable
//  pix_i     in   3*BPC   input pixel
//  hs_o      out  1       hs_i delayed LAT cycles
//  vs_o      out  1       vs_i delayed LAT cycles
//  de_o      out  1       de_i delayed LAT cycles
//  pix_o     out  3*BPC   processed pixel, aligned with de_o
//  dark_o    out  1       current mode (1 = inverting)
// BEHAVIOUR
//  - Reset (rst_ni=0, async): hs_o/vs_o/de_o=0, pix_o=0, dark_o=0, cnt=0, hs_r=0. Reset
//    mid-line takes effect immediately; first valid output is LAT cycles after release.
//  - Line start: ls = hs_i & ~hs_r (hs_r = hs_i registered). Evaluated on every clk_i.
//  - Hysteresis counter cnt, width $clog2(HYST)+1, range 0..HYST, saturating:
//      ls & ~freeze_i & rx_i  & cnt<HYST -> cnt+1 ; ls & ~freeze_i & ~rx_i & cnt>0 -> cnt-1.
//      otherwise hold. freeze_i coincident with ls -> no update (freeze wins).
//  - Mode FSM, states LIGHT(dark_o=0)/DARK(dark_o=1), updates only in the ls cycle:
//      LIGHT -> DARK when next cnt==HYST; DARK -> LIGHT when next cnt==0; else stay.
//      HYST=1: mode follows each unfrozen verdict directly at the next line start.
//  - Mode used by a pixel is the value registered at its input cycle (stage 1), so a
//    transition at ls cycle N affects pixels entering at N+1 onwards.
//  - Pixel path: stage1 registers hs/vs/de/pix and mode; stage2:
//      de=1 & mode=1 -> pix_o = ~pix (per channel, 2^BPC-1 - c); de=1 & mode=0 -> pix_o = pix;
//      de=0 -> pix_o = 0. hs/vs/de simply delayed. Total latency exactly LAT=2 for all outputs.
//  - vs_i does not touch cnt or mode; mode persists across frames.
//  - rx_i is sampled only in ls cycle; value at other cycles is don't-care.
//  - No back-pressure; one pixel accepted and emitted per clock.
// STRUCTURE
//  - Shared package: BPC default, PIX_W = 3*BPC, mode encoding LIGHT=1'b0/DARK=1'b1.
//  - One sub-module: rise_detect (registered-input rising-edge pulse, async active-low reset),
//    used for ls; counter, FSM and 2-stage pipeline stay in lin_render.
// TESTING
//  1 Reset: hold rst_ni=0 with activity on inputs -> all outputs 0; release, feed pix 0x123456
//    de=1 -> pix_o=0x123456 exactly 2 cycles later, dark_o=0.
//  2 HYST=4, rx_i=1 on 4 line starts -> dark_o rises in cycle of 4th ls; pixel 0x00FF80 entering
//    next cycle -> pix_o=0xFF007F two cycles later; pixel in ls cycle itself still unmodified.
//  3 Hysteresis: in DARK, verdicts 0,1,0,0,0 -> cnt 3,4,3,2,1, stays DARK; one more 0 -> LIGHT.
//    Saturation: 6 verdicts rx=1 from 0 -> cnt capped at 4.
//  4 Freeze: freeze_i=1 across 10 line starts with rx_i=1 -> cnt and dark_o unchanged; freeze
//    asserted only in ls cycle -> that verdict dropped, neighbours counted.
//  5 Blanking/timing: de=0 with pix_i=0xFFFFFF in DARK -> pix_o=0; hs/vs/de outputs equal inputs
//    delayed 2 cycles over a full 800x525 frame; vs edges leave dark_o unchanged.
//  6 Async reset mid-line in DARK -> outputs 0 immediately, dark_o=0, cnt=0; verdicts after
//    release restart from LIGHT.

Source files
------------

// File: rtl/lin_render_pkg.sv
// Shared types and constants for the per-line dark-mode renderer.
package lin_render_pkg;

    localparam int unsigned BPC_DEFAULT   = 8;
    localparam int unsigned PIX_W_DEFAULT = 3 * BPC_DEFAULT;

    // Rendering mode; DARK inverts every active pixel.
    typedef enum logic {
        LIGHT = 1'b0,
        DARK  = 1'b1
    } mode_e;

    // Timing controls travelling alongside the pixel word.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Pixel word width for a given channel depth (R,G,B packed).
    function automatic int unsigned pix_w(input int unsigned bpc);
        return 3 * bpc;
    endfunction

endpackage

// File: rtl/lin_render_rise_detect.sv
// Rising-edge pulse: registers the input and flags the cycle it goes 0 -> 1.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_c
);

    logic d_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_c = d_i & ~d_q;

endmodule

// File: rtl/lin_render.sv
// Applies the per-line dark verdict to the live pixel stream with hysteresis;
// mode only changes at line starts so a line is never split.
module lin_render
    import lin_render_pkg::*;
#(
    parameter int unsigned BPC  = BPC_DEFAULT,
    parameter int unsigned HYST = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  freeze_i,
    input  logic                  rx_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  de_i,
    input  logic [pix_w(BPC)-1:0] pix_i,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  de_o,
    output logic [pix_w(BPC)-1:0] pix_o,
    output logic                  dark_o
);

    localparam int unsigned PIX_W = pix_w(BPC);
    localparam int unsigned CNT_W = $clog2(HYST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HYST);

    logic             ls_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    mode_e            mode_q;

    sync_t            sync_q [LAT];
    logic [PIX_W-1:0] pix_s1_q;
    mode_e            mode_s1_q;

    rise_detect u_ls (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (hs_i),
        .rise_c (ls_c)
    );

    // Saturating hysteresis step, taken only on an unfrozen line start.
    always_comb begin
        cnt_nxt = cnt_q;
        if (ls_c && !freeze_i) begin
            if (rx_i) begin
                if (cnt_q < CNT_MAX) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end else if (cnt_q != '0) begin
                cnt_nxt = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter and LIGHT/DARK mode; mode flips only at a line start on the counter extremes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            mode_q <= LIGHT;
        end else begin
            cnt_q <= cnt_nxt;
            if (ls_c) begin
                case (mode_q)
                    LIGHT: if (cnt_nxt == CNT_MAX) mode_q <= DARK;
                    DARK:  if (cnt_nxt == '0)      mode_q <= LIGHT;
                endcase
            end
        end
    end

    // Timing-control delay line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= '{hs: hs_i, vs: vs_i, de: de_i};
            for (int i = 1; i < LAT; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Stage 1 captures the pixel with the mode in force at its entry; stage 2 renders it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_s1_q  <= '0;
            mode_s1_q <= LIGHT;
            pix_o     <= '0;
        end else begin
            pix_s1_q  <= pix_i;
            mode_s1_q <= mode_q;
            if (!sync_q[0].de) begin
                pix_o <= '0;
            end else if (mode_s1_q == DARK) begin
                pix_o <= ~pix_s1_q;
            end else begin
                pix_o <= pix_s1_q;
            end
        end
    end

    assign hs_o   = sync_q[LAT-1].hs;
    assign vs_o   = sync_q[LAT-1].vs;
    assign de_o   = sync_q[LAT-1].de;
    assign dark_o = (mode_q == DARK);

endmodule
